atm_account_fsm: RTL and testbench
==================================

// Module: atm_account_fsm
// PURPOSE
//  Parametrised Moore ATM session controller: card check, PIN check with retry limit and card lockout, then
//  withdraw / balance / deposit / PIN-change on a per-account register bank. Successor to the fixed 10-card
//  ATM FSM; sits between the keypad/card front end and the display/cash-dispense logic.
//  Key change from the old FSM: a request executes once per OKAY rising edge, not once per cycle.
// PARAMETERS
//  ID_W         4      width of CARD_ID
//  NUM_ACCTS    10     valid cards 0..NUM_ACCTS-1 (must be <= 2**ID_W)
//  PIN_DIGITS   4      BCD digits per PIN
//  BAL_W        32     balance / amount width, unsigned
//  INIT_BAL     0      balance of every account after reset
//  MAX_TRIES    3      wrong PINs allowed before the card locks (>=1)
//  TIMEOUT_CYC  1000   inactivity limit in cycles (used only with ATM_TIMEOUT_EN)
// PORTS
//  CLK          in   1                clock, rising edge
//  RESET        in   1                asynchronous, active-high
//  CARD_ID      in   ID_W             card number
//  PIN          in   4*PIN_DIGITS     BCD PIN, digit 0 in [3:0]
//  TRANSACTION  in   2                00 withdraw, 01 balance, 10 deposit, 11 PIN change (new PIN on PIN)
//  AMOUNT       in   BAL_W            withdraw/deposit amount
//  OKAY         in   1                confirm; level input, internally edge-detected
//  CANCEL       in   1                abort / sign out; level
//  SUCCESS      out  1                last request succeeded
//  STATUS       out  4                status code (below)
//  BALANCE      out  BAL_W            balance of the open account, else 0
// BEHAVIOUR
//  - Reset: state IDLE, SUCCESS=0, STATUS=0, BALANCE=0, all balances=INIT_BAL, all tries=0, all locks clear;
//    PIN of account k = BCD digit (k mod 10) repeated; OKAY edge detector prev=0. Reset mid-session discards it.
//  - okr = OKAY & ~okay_prev. All outputs are registered, updated at the edge that samples okr/CANCEL,
//    and held until the next event.
//  - STATUS: 0 IDLE, 1 BAD_CARD, 2 ENTER_PIN, 3 BAD_PIN, 4 LOCKED, 5 MENU, 6 DONE, 7 INSUFFICIENT,
//    8 OVERFLOW, 9 BAD_REQ, 10 TIMEOUT.
//  - IDLE, on okr:
//      CARD_ID >= NUM_ACCTS            -> stay IDLE, STATUS=1.
//      card locked                     -> stay IDLE, STATUS=4.
//      otherwise latch card            -> PIN_CHK, STATUS=2.
//  - PIN_CHK, on okr:
//      PIN match                       -> MENU, STATUS=5, tries[card]=0.
//      mismatch                        -> tries+1, STATUS=3.
//      tries reaches MAX_TRIES         -> lock card, IDLE, STATUS=4.
//    Tries persist across sessions until a correct PIN or RESET.
//  - MENU, on okr: one request executes, then stay in MENU.
//      00 withdraw: 0<AMOUNT<=bal -> bal-=AMOUNT, SUCCESS=1, STATUS=6; else SUCCESS=0 (7 if AMOUNT>bal, 9 if 0).
//      01 balance: SUCCESS=1, STATUS=6; BALANCE is always live in MENU.
//      10 deposit: carry-out of the BAL_W add -> reject, STATUS=8, bal unchanged; AMOUNT=0 -> STATUS=9;
//         else add, SUCCESS=1, STATUS=6.
//      11 PIN change: any digit >9 -> STATUS=9; else store new PIN, SUCCESS=1, STATUS=6.
//    Every non-success MENU outcome sets SUCCESS=0.
//  - CANCEL in PIN_CHK/MENU -> IDLE, STATUS=0, SUCCESS=0, BALANCE=0. CANCEL has priority over a same-cycle okr.
//    CANCEL in IDLE clears STATUS to 0.
//  - OKAY held high performs exactly one action. CARD_ID/PIN/AMOUNT changes without okr are ignored.
// CONFIGURATION
//  ATM_TIMEOUT_EN defined:
//    - Counter clears on any okr or CANCEL.
//    - After TIMEOUT_CYC idle cycles in PIN_CHK/MENU -> IDLE, STATUS=10, SUCCESS=0. Tries are not counted.
//  ATM_TIMEOUT_EN undefined: no counter; sessions persist indefinitely.
// TESTING
//  1 CARD_ID=15, okr -> STATUS=1, still IDLE; CARD_ID=7, okr -> STATUS=2.
//  2 Card 3: wrong PIN x3 -> STATUS 3,3,4, IDLE; card 3 okr -> STATUS=4 until RESET.
//    After RESET, PIN 3333 -> MENU.
//  3 Card 0: deposit 4 with OKAY held 10 cycles -> BALANCE=4 (one deposit);
//    withdraw 16 -> STATUS=7, BALANCE=4; withdraw 4 -> BALANCE=0, SUCCESS=1.
//  4 Deposit so bal=2**BAL_W-1, deposit 1 -> STATUS=8, balance unchanged;
//    change PIN to 1234, cancel, re-login with 1234 -> MENU.
//  5 okr and CANCEL in the same cycle in MENU -> IDLE, no transaction applied;
//    RESET asserted mid-withdraw -> all outputs 0 asynchronously.
//  6 With ATM_TIMEOUT_EN, TIMEOUT_CYC=20: idle 20 cycles in MENU -> STATUS=10, IDLE;
//    without the macro the state stays MENU.

Source files
------------

// File: rtl/atm_account_fsm.sv
// ATM session controller: card check, PIN check with retry lockout, and per-account requests.
// Optional inactivity timeout is enabled by defining ATM_TIMEOUT_EN.
module atm_account_fsm #(
  parameter int unsigned ID_W        = 4,
  parameter int unsigned NUM_ACCTS   = 10,
  parameter int unsigned PIN_DIGITS  = 4,
  parameter int unsigned BAL_W       = 32,
  parameter logic [BAL_W-1:0] INIT_BAL = '0,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [ID_W-1:0]         CARD_ID,
  input  logic [4*PIN_DIGITS-1:0] PIN,
  input  logic [1:0]              TRANSACTION,
  input  logic [BAL_W-1:0]        AMOUNT,
  input  logic                    OKAY,
  input  logic                    CANCEL,
  output logic                    SUCCESS,
  output logic [3:0]              STATUS,
  output logic [BAL_W-1:0]        BALANCE
);

  localparam int unsigned PIN_W = 4 * PIN_DIGITS;
  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;
  localparam logic [TRY_W-1:0] MAX_T      = TRY_W'(MAX_TRIES);
  localparam logic [ID_W:0]    NUM_ACCT_W = (ID_W + 1)'(NUM_ACCTS);

  localparam logic [3:0] ST_IDLE = 4'd0, ST_BAD_CARD = 4'd1, ST_ENTER_PIN = 4'd2,
                         ST_BAD_PIN = 4'd3, ST_LOCKED = 4'd4, ST_MENU = 4'd5,
                         ST_DONE = 4'd6, ST_INSUFF = 4'd7, ST_OVERFLOW = 4'd8,
                         ST_BAD_REQ = 4'd9, ST_TIMEOUT = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_PIN_CHK, S_MENU} state_t;

  state_t             state_q, state_d;
  logic               okay_prev_q;
  logic [ID_W-1:0]    card_q, card_d;
  logic [BAL_W-1:0]   bal_q   [NUM_ACCTS];
  logic [PIN_W-1:0]   pin_q   [NUM_ACCTS];
  logic [TRY_W-1:0]   tries_q [NUM_ACCTS];
  logic [NUM_ACCTS-1:0] lock_q;

  logic               success_q, success_d;
  logic [3:0]         status_q, status_d;
  logic [BAL_W-1:0]   balance_q, balance_d;

  logic               bal_we, pin_we, tries_we, lock_we;
  logic [BAL_W-1:0]   bal_wdata;
  logic [TRY_W-1:0]   tries_wdata;
  logic               okr, timeout;

  logic [BAL_W-1:0]   cur_bal;
  logic [PIN_W-1:0]   cur_pin;
  logic [TRY_W-1:0]   cur_tries, tries_inc;
  logic [BAL_W:0]     dep_sum;

  assign okr       = OKAY & ~okay_prev_q;
  assign cur_bal   = bal_q[card_q];
  assign cur_pin   = pin_q[card_q];
  assign cur_tries = tries_q[card_q];
  assign tries_inc = cur_tries + TRY_W'(1);
  assign dep_sum   = {1'b0, cur_bal} + {1'b0, AMOUNT};

  function automatic logic pin_is_bcd(input logic [PIN_W-1:0] p);
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < int'(PIN_DIGITS); d++)
      if (p[4*d +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

`ifdef ATM_TIMEOUT_EN
  localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
  logic [TMR_W-1:0] tmr_q;
  logic             sess_active;

  assign sess_active = (state_q != S_IDLE);
  assign timeout     = sess_active & ~okr & ~CANCEL & (tmr_q == '0);

  // Down-counter reloads on any activity; terminal count of zero ends the session.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                            tmr_q <= TMR_LOAD;
    else if (!sess_active || okr || CANCEL || tmr_q == '0) tmr_q <= TMR_LOAD;
    else                                                  tmr_q <= tmr_q - TMR_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      okay_prev_q <= 1'b0;
      card_q      <= '0;
      success_q   <= 1'b0;
      status_q    <= ST_IDLE;
      balance_q   <= '0;
      lock_q      <= '0;
      for (int k = 0; k < int'(NUM_ACCTS); k++) begin
        bal_q[k]   <= INIT_BAL;
        tries_q[k] <= '0;
        for (int d = 0; d < int'(PIN_DIGITS); d++)
          pin_q[k][4*d +: 4] <= 4'(k % 10);
      end
    end else begin
      state_q     <= state_d;
      okay_prev_q <= OKAY;
      card_q      <= card_d;
      success_q   <= success_d;
      status_q    <= status_d;
      balance_q   <= balance_d;
      if (bal_we)   bal_q[card_q]   <= bal_wdata;
      if (pin_we)   pin_q[card_q]   <= PIN;
      if (tries_we) tries_q[card_q] <= tries_wdata;
      if (lock_we)  lock_q[card_q]  <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    card_d      = card_q;
    bal_we      = 1'b0;
    bal_wdata   = cur_bal;
    pin_we      = 1'b0;
    tries_we    = 1'b0;
    tries_wdata = cur_tries;
    lock_we     = 1'b0;
    success_d   = success_q;
    status_d    = status_q;
    unique case (state_q)
      S_IDLE: begin
        if (CANCEL) begin
          status_d = ST_IDLE;
        end else if (okr) begin
          success_d = 1'b0;
          if ({1'b0, CARD_ID} >= NUM_ACCT_W) begin
            status_d = ST_BAD_CARD;
          end else if (lock_q[CARD_ID]) begin
            status_d = ST_LOCKED;
          end else begin
            card_d   = CARD_ID;
            state_d  = S_PIN_CHK;
            status_d = ST_ENTER_PIN;
          end
        end
      end
      S_PIN_CHK, S_MENU: begin
        if (CANCEL) begin
          state_d   = S_IDLE;
          status_d  = ST_IDLE;
          success_d = 1'b0;
        end else if (timeout) begin
          state_d   = S_IDLE;
          status_d  = ST_TIMEOUT;
          success_d = 1'b0;
        end else if (okr && state_q == S_PIN_CHK) begin
          tries_we = 1'b1;
          if (PIN == cur_pin) begin
            tries_wdata = '0;
            state_d     = S_MENU;
            status_d    = ST_MENU;
          end else if (tries_inc >= MAX_T) begin
            tries_wdata = MAX_T;
            lock_we     = 1'b1;
            state_d     = S_IDLE;
            status_d    = ST_LOCKED;
          end else begin
            tries_wdata = tries_inc;
            status_d    = ST_BAD_PIN;
          end
        end else if (okr) begin
          success_d = 1'b0;
          unique case (TRANSACTION)
            2'b00: begin
              if (AMOUNT == '0)           status_d = ST_BAD_REQ;
              else if (AMOUNT > cur_bal)  status_d = ST_INSUFF;
              else begin
                bal_we    = 1'b1;
                bal_wdata = cur_bal - AMOUNT;
                success_d = 1'b1;
                status_d  = ST_DONE;
              end
            end
            2'b01: begin
              success_d = 1'b1;
              status_d  = ST_DONE;
            end
            2'b10: begin
              if (dep_sum[BAL_W])         status_d = ST_OVERFLOW;
              else if (AMOUNT == '0)      status_d = ST_BAD_REQ;
              else begin
                bal_we    = 1'b1;
                bal_wdata = dep_sum[BAL_W-1:0];
                success_d = 1'b1;
                status_d  = ST_DONE;
              end
            end
            default: begin
              if (!pin_is_bcd(PIN))       status_d = ST_BAD_REQ;
              else begin
                pin_we    = 1'b1;
                success_d = 1'b1;
                status_d  = ST_DONE;
              end
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Balance is only shown while an account is open, and reflects this cycle's update.
  always_comb begin
    balance_d = '0;
    if (state_d == S_MENU) balance_d = bal_we ? bal_wdata : cur_bal;
    SUCCESS = success_q;
    STATUS  = status_q;
    BALANCE = balance_q;
  end

endmodule

// File: tb/tb_atm_account_fsm.sv
// Directed bench for atm_account_fsm: vector table plus hand-written multi-cycle sequences.
// Timeout checks follow ATM_TIMEOUT_EN, with TIMEOUT_CYC set to 20.
module tb_atm_account_fsm;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  CARD_ID = '0;
  logic [15:0] PIN = '0;
  logic [1:0]  TRANSACTION = '0;
  logic [31:0] AMOUNT = '0;
  logic        OKAY = 1'b0;
  logic        CANCEL = 1'b0;
  logic        SUCCESS;
  logic [3:0]  STATUS;
  logic [31:0] BALANCE;

  int n_checks = 0;
  int n_fails  = 0;

  atm_account_fsm #(.TIMEOUT_CYC(20)) dut (
    .CLK(CLK), .RESET(RESET), .CARD_ID(CARD_ID), .PIN(PIN), .TRANSACTION(TRANSACTION),
    .AMOUNT(AMOUNT), .OKAY(OKAY), .CANCEL(CANCEL),
    .SUCCESS(SUCCESS), .STATUS(STATUS), .BALANCE(BALANCE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        ok;
    logic        cancel;
    logic [3:0]  card;
    logic [15:0] pin;
    logic [1:0]  trans;
    logic [31:0] amount;
    logic [3:0]  exp_status;
    logic        chk_success;
    logic        exp_success;
    logic [31:0] exp_balance;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input string name, input logic ok, input logic cancel, input logic [3:0] card,
                     input logic [15:0] pin, input logic [1:0] trans, input logic [31:0] amount,
                     input logic [3:0] est, input logic csu, input logic esu, input logic [31:0] ebal);
    vec_t v;
    v.name = name; v.ok = ok; v.cancel = cancel; v.card = card; v.pin = pin; v.trans = trans;
    v.amount = amount; v.exp_status = est; v.chk_success = csu; v.exp_success = esu;
    v.exp_balance = ebal;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    CARD_ID = v.card; PIN = v.pin; TRANSACTION = v.trans; AMOUNT = v.amount;
    OKAY = v.ok; CANCEL = v.cancel;
    step();
    check({v.name, ".status"}, 32'(STATUS), 32'(v.exp_status));
    check({v.name, ".balance"}, BALANCE, v.exp_balance);
    if (v.chk_success) check({v.name, ".success"}, 32'(SUCCESS), 32'(v.exp_success));
    OKAY = 1'b0; CANCEL = 1'b0;
    step();
  endtask

  task automatic op(input string name, input logic cancel, input logic [3:0] card, input logic [15:0] pin,
                    input logic [1:0] trans, input logic [31:0] amount, input logic [3:0] est);
    vec_t v;
    v.name = name; v.ok = ~cancel; v.cancel = cancel; v.card = card; v.pin = pin; v.trans = trans;
    v.amount = amount; v.exp_status = est; v.chk_success = 1'b0; v.exp_success = 1'b0;
    v.exp_balance = 32'(0);
    CARD_ID = v.card; PIN = v.pin; TRANSACTION = v.trans; AMOUNT = v.amount;
    OKAY = v.ok; CANCEL = v.cancel;
    step();
    check({name, ".status"}, 32'(STATUS), 32'(est));
    OKAY = 1'b0; CANCEL = 1'b0;
    step();
  endtask

  initial begin
    // name, ok, cancel, card, pin, trans, amount, status, chk_succ, succ, balance
    add("bad_card",      1, 0, 4'd15, 16'h0000, 2'b00, 0,  4'd1, 0, 0, 0);
    add("card7",         1, 0, 4'd7,  16'h0000, 2'b00, 0,  4'd2, 0, 0, 0);
    add("cancel_pin",    0, 1, 4'd7,  16'h0000, 2'b00, 0,  4'd0, 1, 0, 0);
    add("card3",         1, 0, 4'd3,  16'h0000, 2'b00, 0,  4'd2, 0, 0, 0);
    add("c3_wrong1",     1, 0, 4'd3,  16'h0000, 2'b00, 0,  4'd3, 0, 0, 0);
    add("c3_wrong2",     1, 0, 4'd3,  16'h1111, 2'b00, 0,  4'd3, 0, 0, 0);
    add("c3_wrong3",     1, 0, 4'd3,  16'h0000, 2'b00, 0,  4'd4, 0, 0, 0);
    add("c3_locked",     1, 0, 4'd3,  16'h3333, 2'b00, 0,  4'd4, 0, 0, 0);
    add("card0",         1, 0, 4'd0,  16'h0000, 2'b00, 0,  4'd2, 0, 0, 0);
    add("c0_pin",        1, 0, 4'd0,  16'h0000, 2'b00, 0,  4'd5, 0, 0, 0);
    add("dep4",          1, 0, 4'd0,  16'h0000, 2'b10, 4,  4'd6, 1, 1, 4);
    add("wd16_insuff",   1, 0, 4'd0,  16'h0000, 2'b00, 16, 4'd7, 1, 0, 4);
    add("wd0_badreq",    1, 0, 4'd0,  16'h0000, 2'b00, 0,  4'd9, 1, 0, 4);
    add("bal_query",     1, 0, 4'd0,  16'h0000, 2'b01, 0,  4'd6, 1, 1, 4);
    add("wd4",           1, 0, 4'd0,  16'h0000, 2'b00, 4,  4'd6, 1, 1, 0);
    add("dep_max",       1, 0, 4'd0,  16'h0000, 2'b10, 32'hFFFF_FFFF, 4'd6, 1, 1, 32'hFFFF_FFFF);
    add("dep_overflow",  1, 0, 4'd0,  16'h0000, 2'b10, 1,  4'd8, 1, 0, 32'hFFFF_FFFF);
    add("pinchg_bad",    1, 0, 4'd0,  16'h12A4, 2'b11, 0,  4'd9, 1, 0, 32'hFFFF_FFFF);
    add("pinchg_1234",   1, 0, 4'd0,  16'h1234, 2'b11, 0,  4'd6, 1, 1, 32'hFFFF_FFFF);
    add("cancel_menu",   0, 1, 4'd0,  16'h0000, 2'b00, 0,  4'd0, 1, 0, 0);
    add("relogin_card0", 1, 0, 4'd0,  16'h0000, 2'b00, 0,  4'd2, 0, 0, 0);
    add("old_pin",       1, 0, 4'd0,  16'h0000, 2'b00, 0,  4'd3, 0, 0, 0);
    add("new_pin",       1, 0, 4'd0,  16'h1234, 2'b00, 0,  4'd5, 0, 0, 32'hFFFF_FFFF);
    add("dep0_badreq",   1, 0, 4'd0,  16'h1234, 2'b10, 0,  4'd9, 1, 0, 32'hFFFF_FFFF);
    add("wd1",           1, 0, 4'd0,  16'h1234, 2'b00, 1,  4'd6, 1, 1, 32'hFFFF_FFFE);

    #1;
    check("reset.status", 32'(STATUS), 32'd0);
    check("reset.success", 32'(SUCCESS), 32'd0);
    check("reset.balance", BALANCE, 32'd0);
    @(negedge CLK); RESET = 1'b0;
    step();

    foreach (vecs[i]) apply(vecs[i]);

    // OKAY held for 10 cycles with AMOUNT changing mid-hold: exactly one withdrawal of 5.
    TRANSACTION = 2'b00; AMOUNT = 32'd5; OKAY = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 3) AMOUNT = 32'd7;
    end
    check("held_ok.balance", BALANCE, 32'hFFFF_FFF9);
    check("held_ok.status", 32'(STATUS), 32'd6);
    OKAY = 1'b0;
    step();

    // Input changes without an OKAY edge leave everything untouched.
    TRANSACTION = 2'b00; AMOUNT = 32'd1;
    step(); step();
    check("no_okr.balance", BALANCE, 32'hFFFF_FFF9);

    // okr and CANCEL together: cancel wins and the withdrawal is dropped.
    TRANSACTION = 2'b00; AMOUNT = 32'd1; OKAY = 1'b1; CANCEL = 1'b1;
    step();
    check("ok_cancel.status", 32'(STATUS), 32'd0);
    check("ok_cancel.balance", BALANCE, 32'd0);
    OKAY = 1'b0; CANCEL = 1'b0;
    step();
    op("relogin2_card", 0, 4'd0, 16'h0000, 2'b00, 0, 4'd2);
    op("relogin2_pin",  0, 4'd0, 16'h1234, 2'b00, 0, 4'd5);
    check("ok_cancel.bal_kept", BALANCE, 32'hFFFF_FFF9);

    // Inactivity: the trailing idle edge of the login above already counted once.
    for (int c = 0; c < 18; c++) step();
    check("timeout.before", 32'(STATUS), 32'd5);
    step();
`ifdef ATM_TIMEOUT_EN
    check("timeout.status", 32'(STATUS), 32'd10);
    check("timeout.balance", BALANCE, 32'd0);
`else
    for (int c = 0; c < 10; c++) step();
    check("no_timeout.status", 32'(STATUS), 32'd5);
    check("no_timeout.balance", BALANCE, 32'hFFFF_FFF9);
`endif

    op("pre_rst_cancel", 1, 4'd0, 16'h0000, 2'b00, 0, 4'd0);
    op("pre_rst_card",   0, 4'd0, 16'h0000, 2'b00, 0, 4'd2);
    op("pre_rst_pin",    0, 4'd0, 16'h1234, 2'b00, 0, 4'd5);

    // Reset asserted mid-withdraw clears outputs without waiting for a clock edge.
    TRANSACTION = 2'b00; AMOUNT = 32'd1; OKAY = 1'b1;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("async_rst.status", 32'(STATUS), 32'd0);
    check("async_rst.balance", BALANCE, 32'd0);
    check("async_rst.success", 32'(SUCCESS), 32'd0);
    OKAY = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    step();

    op("post_rst_card3", 0, 4'd3, 16'h0000, 2'b00, 0, 4'd2);
    op("post_rst_pin3",  0, 4'd3, 16'h3333, 2'b00, 0, 4'd5);
    op("post_rst_cancel", 1, 4'd3, 16'h0000, 2'b00, 0, 4'd0);
    op("post_rst_card0", 0, 4'd0, 16'h0000, 2'b00, 0, 4'd2);
    op("post_rst_pin0",  0, 4'd0, 16'h0000, 2'b00, 0, 4'd5);
    check("post_rst.bal0", BALANCE, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
